// File: rtl/mcdt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mcdt_arbiter
// Purpose  : Three-channel burst arbiter between the per-channel slave FIFOs
//            and the MCDT output formatter. One channel is granted at a time
//            for up to cfg_burst_i words. The granted show-ahead FIFO is
//            popped, and its words are forwarded on a registered output
//            stream tagged with the source channel id. Round-robin or fixed
//            priority (ch0 > ch1 > ch2) arbitration is selected at run time.
//
// Ports    : clk_i        - clock, rising edge
//            rst_i        - synchronous, active-high reset
//            chN_req_i    - channel N FIFO not empty (N = 0..2)
//            chN_data_i   - channel N FIFO head word, valid while chN_req_i
//            chN_ack_o    - pop strobe to channel N FIFO
//            cfg_mode_i   - 0 = round-robin, 1 = fixed priority
//            cfg_burst_i  - maximum words per grant (0 behaves as 1)
//            mcdt_data_o  - output word, zero when mcdt_val_o is low
//            mcdt_val_o   - output word valid, one cycle per word
//            mcdt_id_o    - source channel of the last output word
//            busy_o       - high while a grant is active
//
// Revision : 1.0 - initial release
// ============================================================================
module mcdt_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          ch0_req_i,
  input  logic [DW-1:0] ch0_data_i,
  output logic          ch0_ack_o,

  input  logic          ch1_req_i,
  input  logic [DW-1:0] ch1_data_i,
  output logic          ch1_ack_o,

  input  logic          ch2_req_i,
  input  logic [DW-1:0] ch2_data_i,
  output logic          ch2_ack_o,

  input  logic          cfg_mode_i,
  input  logic [2:0]    cfg_burst_i,

  output logic [DW-1:0] mcdt_data_o,
  output logic          mcdt_val_o,
  output logic [1:0]    mcdt_id_o,
  output logic          busy_o
);

  // --------------------------------------------------------------------------
  // Constants and state encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic [1:0] C_CH0       = 2'd0;
  localparam logic [1:0] C_CH1       = 2'd1;
  localparam logic [1:0] C_CH2       = 2'd2;
  localparam logic       C_MODE_RR   = 1'b0;
  localparam logic [2:0] C_BLEN_MIN  = 3'd1;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [1:0]    gnt_q,   gnt_d;
  logic [2:0]    cnt_q,   cnt_d;
  logic [2:0]    blen_q,  blen_d;
  logic [1:0]    ptr_q,   ptr_d;

  logic [DW-1:0] data_q,  data_d;
  logic          val_q,   val_d;
  logic [1:0]    id_q,    id_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic          w_req_any;
  logic [1:0]    w_fix_pick;
  logic [1:0]    w_rr_pick;
  logic [1:0]    w_winner;
  logic [2:0]    w_blen_cfg;
  logic          w_gnt_req;
  logic [DW-1:0] w_gnt_data;
  logic          w_ack_any;
  logic          w_last_word;
  logic [1:0]    w_ptr_next;

  assign w_req_any = ch0_req_i | ch1_req_i | ch2_req_i;

  // Fixed priority: lowest requesting index wins. The fall-through value is
  // only consumed when at least one request is present.
  always_comb begin
    w_fix_pick = C_CH2;
    if (ch0_req_i) begin
      w_fix_pick = C_CH0;
    end else if (ch1_req_i) begin
      w_fix_pick = C_CH1;
    end
  end

  // Round-robin: first requester scanning ptr, ptr+1, ptr+2 (mod 3).
  // ptr never holds 3; if it ever did, scanning from channel 0 is a safe
  // recovery.
  always_comb begin
    w_rr_pick = C_CH0;
    case (ptr_q)
      C_CH1: begin
        if      (ch1_req_i) w_rr_pick = C_CH1;
        else if (ch2_req_i) w_rr_pick = C_CH2;
        else                w_rr_pick = C_CH0;
      end
      C_CH2: begin
        if      (ch2_req_i) w_rr_pick = C_CH2;
        else if (ch0_req_i) w_rr_pick = C_CH0;
        else                w_rr_pick = C_CH1;
      end
      default: begin
        if      (ch0_req_i) w_rr_pick = C_CH0;
        else if (ch1_req_i) w_rr_pick = C_CH1;
        else                w_rr_pick = C_CH2;
      end
    endcase
  end

  assign w_winner   = (cfg_mode_i == C_MODE_RR) ? w_rr_pick : w_fix_pick;
  assign w_blen_cfg = (cfg_burst_i == 3'd0) ? C_BLEN_MIN : cfg_burst_i;

  // Request and head word of the granted channel. A grant value of 3 selects
  // nothing, so no ack can be produced from it.
  always_comb begin
    w_gnt_req  = 1'b0;
    w_gnt_data = '0;
    case (gnt_q)
      C_CH0: begin
        w_gnt_req  = ch0_req_i;
        w_gnt_data = ch0_data_i;
      end
      C_CH1: begin
        w_gnt_req  = ch1_req_i;
        w_gnt_data = ch1_data_i;
      end
      C_CH2: begin
        w_gnt_req  = ch2_req_i;
        w_gnt_data = ch2_data_i;
      end
      default: begin
        w_gnt_req  = 1'b0;
        w_gnt_data = '0;
      end
    endcase
  end

  // Acks are combinational from the registered grant so the FIFO pops in the
  // same cycle it presents its head word. Reset suppresses them immediately.
  assign w_ack_any = (state_q == BURST) && w_gnt_req && !rst_i;

  assign ch0_ack_o = w_ack_any && (gnt_q == C_CH0);
  assign ch1_ack_o = w_ack_any && (gnt_q == C_CH1);
  assign ch2_ack_o = w_ack_any && (gnt_q == C_CH2);

  assign w_last_word = (cnt_q == (blen_q - 3'd1));

  // Round-robin start index for the next arbitration: the channel after the
  // one that just released.
  always_comb begin
    case (gnt_q)
      C_CH0:   w_ptr_next = C_CH1;
      C_CH1:   w_ptr_next = C_CH2;
      default: w_ptr_next = C_CH0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    blen_d  = blen_q;
    ptr_d   = ptr_q;

    case (state_q)
      IDLE: begin
        // Configuration is sampled only here, so mid-burst changes take
        // effect at the next grant.
        if (w_req_any) begin
          gnt_d   = w_winner;
          cnt_d   = 3'd0;
          blen_d  = w_blen_cfg;
          state_d = BURST;
        end
      end
      default: begin
        if (gnt_q == 2'd3) begin
          // Illegal grant: fall back to IDLE without touching the pointer.
          state_d = IDLE;
        end else if (w_ack_any) begin
          if (w_last_word) begin
            state_d = IDLE;
            ptr_d   = w_ptr_next;
          end else begin
            cnt_d   = cnt_q + 3'd1;
          end
        end else begin
          // Granted FIFO ran empty: release early, possibly with 0 words.
          state_d = IDLE;
          ptr_d   = w_ptr_next;
        end
      end
    endcase
  end

  // Output stream register: data is zeroed on idle cycles, id holds the
  // source of the most recent word.
  always_comb begin
    val_d  = w_ack_any;
    data_d = w_ack_any ? w_gnt_data : '0;
    id_d   = w_ack_any ? gnt_q : id_q;
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= C_CH0;
      cnt_q   <= 3'd0;
      blen_q  <= C_BLEN_MIN;
      ptr_q   <= C_CH0;
      data_q  <= '0;
      val_q   <= 1'b0;
      id_q    <= C_CH0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      blen_q  <= blen_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      val_q   <= val_d;
      id_q    <= id_d;
    end
  end

  assign mcdt_data_o = data_q;
  assign mcdt_val_o  = val_q;
  assign mcdt_id_o   = id_q;
  assign busy_o      = (state_q == BURST);

endmodule
`default_nettype wire
